// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding is fixed so that state values seen on a debug bus stay stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit count counter width; a 2-bit operand still needs one counter bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle of the serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  // Requester side: presents operands and consumes the result.
  modport master (
    output start_valid, a, b, done_ready,
    input  start_ready, done_valid, diff, borrow_out, busy
  );

  // Subtractor side.
  modport slave (
    input  start_valid, a, b, done_ready,
    output start_ready, done_valid, diff, borrow_out, busy
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - gate-level half and full subtractor cells

// One-bit x - y without incoming borrow.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

// One-bit x - y - bin: two half subtractors chained, borrows merged by an OR,
// mirroring the structure of the adder cells.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic bout,
  output logic d
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_xy (
    .x    (x),
    .y    (y),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs_bin (
    .x    (d1),
    .y    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a - b, LSB first, valid/ready at both ends
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             borrow_out_q;
  logic [CNT_W-1:0] count;

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  logic             start_ready_c;
  logic             done_valid_c;
  logic             busy_c;

  assign accept   = bus.start_valid && start_ready_c;
  assign last_bit = (count == LAST_BIT);

  // The single arithmetic cell; the borrow flop closes the serial chain.
  full_subtractor u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .bout (cell_bout),
    .d    (cell_d)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, finish on the last bit, release on hand-off.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept)                           state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)                         state_nxt = ST_DONE;
      ST_DONE: if (done_valid_c && bus.done_ready)   state_nxt = ST_IDLE;
      default:                                       state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from state.
  always_comb begin
    start_ready_c = 1'b0;
    done_valid_c  = 1'b0;
    busy_c        = 1'b0;
    unique case (state)
      ST_IDLE: start_ready_c = 1'b1;
      ST_RUN:  busy_c        = 1'b1;
      ST_DONE: begin
        done_valid_c = 1'b1;
        busy_c       = 1'b1;
      end
      default: start_ready_c = 1'b0;
    endcase
  end

  // Datapath: capture operands on accept, then one bit per clock while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh         <= '0;
      b_sh         <= '0;
      diff_q       <= '0;
      borrow       <= 1'b0;
      borrow_out_q <= 1'b0;
      count        <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        ST_RUN: begin
          diff_q <= {cell_d, diff_q[WIDTH-1:1]};
          borrow <= cell_bout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          count  <= count + CNT_W'(1);
          if (last_bit) begin
            borrow_out_q <= cell_bout;
          end
        end
        default: begin
          // DONE holds the result until the consumer takes it.
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_c;
  assign bus.done_valid  = done_valid_c;
  assign bus.busy        = busy_c;
  assign bus.diff        = diff_q;
  assign bus.borrow_out  = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic cx, cy, cb, cd, cbo;

  full_subtractor u_cell (
    .x    (cx),
    .y    (cy),
    .bin  (cb),
    .bout (cbo),
    .d    (cd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one operation from IDLE (called at a negedge) and checks it against
  // plain arithmetic. hold: cycles done_ready stays low in DONE.
  // inj: RUN cycle index at which a stray start (9,9) is pulsed, -1 for none.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int hold, input bit early_ready, input int inj);
    logic [W-1:0] ed;
    logic         eb;
    int           cyc;
    ed = av - bv;
    eb = (av < bv);
    bus.done_ready  = early_ready;
    bus.a           = av;
    bus.b           = bv;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    chk("start_ready_run", 32'(bus.start_ready), 32'd0);
    chk("busy_run", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.done_valid && cyc < 50) begin
      if (cyc == inj) begin
        bus.start_valid = 1'b1;
        bus.a = W'(9);
        bus.b = W'(9);
      end else begin
        bus.start_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(W));
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("borrow_out", 32'(bus.borrow_out), 32'(eb));
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.done_valid), 32'd1);
        chk("hold_diff", 32'(bus.diff), 32'(ed));
        chk("hold_borrow", 32'(bus.borrow_out), 32'(eb));
      end
      bus.done_ready = 1'b1;
    end
    @(negedge clk);
    chk("idle_start_ready", 32'(bus.start_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done_valid", 32'(bus.done_valid), 32'd0);
    chk("idle_diff_kept", 32'(bus.diff), 32'(ed));
    bus.done_ready = 1'b0;
  endtask

  initial begin
    int   seen_dv;
    int   val;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    cx = 1'b0; cy = 1'b0; cb = 1'b0;

    // Cell truth table from signed arithmetic x - y - bin.
    for (int i = 0; i < 8; i++) begin
      cx = i[2]; cy = i[1]; cb = i[0];
      #1;
      val = int'(cx) - int'(cy) - int'(cb);
      chk("cell_d", 32'(cd), 32'(val & 1));
      chk("cell_bout", 32'(cbo), 32'(val < 0));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(W'(200), W'(55), 0, 1'b1, -1);
    do_op(W'(5), W'(10), 0, 1'b1, -1);
    do_op(W'(0), W'(1), 0, 1'b0, -1);
    do_op(W'(255), W'(255), 0, 1'b1, -1);
    do_op(W'(100), W'(1), 5, 1'b0, -1);
    do_op(W'(50), W'(20), 0, 1'b1, 2);
    @(negedge clk);
    chk("no_second_op", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    bus.a = W'(50);
    bus.b = W'(20);
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done_valid", 32'(bus.done_valid), 32'd0);
    chk("abort_start_ready", 32'(bus.start_ready), 32'd1);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_dv = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.done_valid) seen_dv++;
    end
    chk("abort_no_done", 32'(seen_dv), 32'd0);
    do_op(W'(7), W'(3), 0, 1'b1, -1);

    // Randomized operands, readiness and backpressure.
    for (int n = 0; n < 20; n++) begin
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor that computes a − b over WIDTH cycles, LSB first. It processes one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the inverse-arithmetic companion to the team's adder cells. Operands enter and the result leaves through a valid/ready handshake, so the block can sit between a register-file read port and a result sink that may apply backpressure.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands a, b presented
start_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
done_valid  output  1  diff and borrow_out hold a final result
done_ready  input  1  consumer accepts the result
diff  output  WIDTH  (a − b) mod 2^WIDTH
borrow_out  output  1  1 iff a < b (unsigned)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, takes effect immediately, independent of clk):
  - State goes to IDLE.
  - a_sh, b_sh, diff, borrow, count and borrow_out are all cleared to 0.
  - done_valid=0, busy=0, start_ready=1.
- States: IDLE, RUN, DONE. start_ready, done_valid and busy are decoded combinationally from the state.
- IDLE:
  - On the edge where start_valid && start_ready: a_sh<=a, b_sh<=b, borrow<=0, count<=0, go to RUN.
  - a and b are ignored at all other times.
- RUN: on each edge,
  - The full_subtractor is fed x=a_sh[0], y=b_sh[0], bin=borrow.
  - Its output d is shifted into diff from the MSB end: diff <= {d, diff[WIDTH-1:1]}.
  - borrow <= bout; a_sh and b_sh shift right by 1; count <= count+1.
  - On the edge where count==WIDTH-1 the last bit is processed, borrow_out <= bout, and the state goes to DONE.
- Latency: exactly WIDTH clocks from the accept edge to the first cycle with done_valid=1.
- DONE:
  - done_valid=1; diff and borrow_out are held stable.
  - On the edge where done_valid && done_ready, go to IDLE.
  - If done_ready stays low, DONE is held indefinitely with no change to any output.
- The consumer may drive done_ready high before done_valid rises; the handshake completes on the first DONE cycle.
- start_valid while in RUN or DONE is ignored (start_ready=0). Operands are never captured mid-computation.
- There is no overlap between result hand-off and a new accept; at least one IDLE cycle separates operations.
- diff keeps the last result in IDLE. It is shifting and meaningless to consumers during RUN; consumers may only sample it when done_valid=1.
- Reset mid-RUN or mid-DONE aborts the operation: no done_valid pulse and no partial result are presented.
- Arithmetic: diff equals (a + ~b + 1) mod 2^WIDTH; borrow_out equals the final borrow of the serial chain.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Counter width constant CNT_W = $clog2(WIDTH).
- Sub-module full_subtractor (ports x, y, bin, bout, d), built from two half_subtractor gate-level cells plus an OR, mirroring the team's full-adder structure:
  - d = x^y^bin
  - bout = (~x&y) | (~(x^y)&bin)
- serial_subtractor instantiates exactly one full_subtractor.

Test Plan:
- Cell exhaustive: full_subtractor over all 8 (x,y,bin) combinations -> d, bout match the truth table (e.g. 0,1,1 -> d=0, bout=1).
- Basic: WIDTH=8, a=200, b=55, done_ready=1 -> done_valid rises exactly 8 clocks after accept; diff=145, borrow_out=0; start_ready back high the cycle after hand-off.
- Borrow cases:
  - a=5, b=10 -> diff=251, borrow_out=1.
  - a=0, b=1 -> diff=8'hFF, borrow_out=1.
  - a=8'hFF, b=8'hFF -> diff=0, borrow_out=0.
- Backpressure: a=100, b=1 with done_ready held low 5 cycles in DONE -> diff=99 and done_valid stable for all 5 cycles; return to IDLE on the first done_ready=1 edge.
- Ignored start: pulse start_valid with a=9, b=9 on RUN cycle 3 of a=50, b=20 -> result diff=30; no second operation starts.
- Reset abort: drop rst_n asynchronously on RUN cycle 4 -> all outputs zero immediately, no done_valid; a fresh a=7, b=3 afterwards -> diff=4, borrow_out=0.
